// File: rtl/tone_cfg_pkg.sv
// rtl/tone_cfg_pkg.sv - shared constants, state encoding and bus packing helper for the tone config sequencer
package tone_cfg_pkg;

  localparam int NUM_TONES = 8;
  localparam int TONE_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RAMP = 2'd2
  } state_t;

  // Low bit of tone slot `tone` in a {tone7..tone0} packed bus of `width`-bit fields.
  function automatic int lane_lo(input int tone, input int width);
    return tone * width;
  endfunction

endpackage

// File: rtl/gain_ramp_lane.sv
// rtl/gain_ramp_lane.sv - one gain lane: steps cur toward target by at most GAIN_STEP, never overshooting
module gain_ramp_lane #(
  parameter int GAIN_W    = 18,
  parameter int GAIN_STEP = 1024
) (
  input  logic [GAIN_W-1:0] cur,
  input  logic [GAIN_W-1:0] target,
  input  logic              step_en,
  output logic [GAIN_W-1:0] next,
  output logic              at_target
);

  localparam logic [GAIN_W:0]   STEP   = (GAIN_W+1)'(GAIN_STEP);
  localparam logic [GAIN_W-1:0] STEP_N = STEP[GAIN_W-1:0];

  logic signed [GAIN_W:0] diff;
  logic        [GAIN_W:0] mag;
  logic [GAIN_W-1:0]      moved;

  // One extra bit on the difference keeps full-scale swings from wrapping.
  always_comb begin
    diff      = $signed({target[GAIN_W-1], target}) - $signed({cur[GAIN_W-1], cur});
    mag       = diff[GAIN_W] ? $unsigned(-diff) : $unsigned(diff);
    moved     = diff[GAIN_W] ? (cur - STEP_N) : (cur + STEP_N);
    at_target = (cur == target);
    next      = cur;
    if (step_en && !at_target) begin
      if ((STEP == '0) || (mag <= STEP)) begin
        next = target;
      end else begin
        next = moved;
      end
    end
  end

endmodule

// File: rtl/tone_cfg_sequencer.sv
// rtl/tone_cfg_sequencer.sv - shadow bank, sample-aligned atomic commit and gain ramping for Channel-A config buses
module tone_cfg_sequencer
  import tone_cfg_pkg::*;
#(
  parameter int IDX_W     = 10,
  parameter int GAIN_W    = 18,
  parameter int DLY_W     = 16,
  parameter int GAIN_STEP = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_wr_valid,
  output logic                          cfg_wr_ready,
  input  logic [TONE_W-1:0]             cfg_wr_tone,
  input  logic [IDX_W-1:0]              cfg_wr_index,
  input  logic [GAIN_W-1:0]             cfg_wr_gain,
  input  logic                          commit_valid,
  output logic                          commit_ready,
  input  logic [DLY_W-1:0]              commit_delay,
  input  logic                          sample_tick,
  output logic [NUM_TONES*IDX_W-1:0]    index_a_bus,
  output logic [NUM_TONES*GAIN_W-1:0]   gain_a_bus,
  output logic                          busy,
  output logic                          commit_done
);

  logic [IDX_W-1:0]  sh_idx    [NUM_TONES];
  logic [GAIN_W-1:0] sh_gain   [NUM_TONES];
  logic [IDX_W-1:0]  idx_act   [NUM_TONES];
  logic [GAIN_W-1:0] gain_act  [NUM_TONES];
  logic [GAIN_W-1:0] tgt       [NUM_TONES];
  logic [GAIN_W-1:0] lane_next [NUM_TONES];
  logic [NUM_TONES-1:0] lane_at;

  state_t           state;
  logic [DLY_W-1:0] cnt;
  logic             rdy;
  logic             wr_hs;
  logic             cm_hs;

  assign wr_hs        = rdy & cfg_wr_valid;
  assign cm_hs        = rdy & commit_valid;
  assign cfg_wr_ready = rdy;
  assign commit_ready = rdy;

  for (genvar i = 0; i < NUM_TONES; i++) begin : g_lane
    localparam int ILO = lane_lo(i, IDX_W);
    localparam int GLO = lane_lo(i, GAIN_W);

    gain_ramp_lane #(
      .GAIN_W    (GAIN_W),
      .GAIN_STEP (GAIN_STEP)
    ) u_lane (
      .cur       (gain_act[i]),
      .target    (tgt[i]),
      .step_en   (sample_tick),
      .next      (lane_next[i]),
      .at_target (lane_at[i])
    );

    assign index_a_bus[ILO +: IDX_W] = idx_act[i];
    assign gain_a_bus[GLO +: GAIN_W] = gain_act[i];
  end

  // commit_done is raised while still in RAMP so busy covers the done cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rdy         <= 1'b0;
      busy        <= 1'b0;
      commit_done <= 1'b0;
      for (int i = 0; i < NUM_TONES; i++) begin
        sh_idx[i]   <= '0;
        sh_gain[i]  <= '0;
        idx_act[i]  <= '0;
        gain_act[i] <= '0;
        tgt[i]      <= '0;
      end
    end else begin
      commit_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (wr_hs) begin
            sh_idx[cfg_wr_tone]  <= cfg_wr_index;
            sh_gain[cfg_wr_tone] <= cfg_wr_gain;
          end
          if (cm_hs) begin
            state <= WAIT;
            cnt   <= commit_delay;
            rdy   <= 1'b0;
            busy  <= 1'b1;
          end else begin
            rdy <= 1'b1;
          end
        end
        WAIT: begin
          if (sample_tick) begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              for (int i = 0; i < NUM_TONES; i++) begin
                idx_act[i] <= sh_idx[i];
                tgt[i]     <= sh_gain[i];
                if (GAIN_STEP == 0) gain_act[i] <= sh_gain[i];
              end
              state <= RAMP;
            end
          end
        end
        RAMP: begin
          if (commit_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            rdy   <= 1'b1;
          end else if (&lane_at) begin
            commit_done <= 1'b1;
          end else begin
            for (int i = 0; i < NUM_TONES; i++) gain_act[i] <= lane_next[i];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_cfg_sequencer.sv
// tb/tb_tone_cfg_sequencer.sv - bench for tone_cfg_sequencer: ramping (step 1024) and jumping (step 0) instances vs a behavioural model
module tb_tone_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr_valid = 1'b0;
  logic [2:0]  cfg_wr_tone = '0;
  logic [9:0]  cfg_wr_index = '0;
  logic [17:0] cfg_wr_gain = '0;
  logic        commit_valid = 1'b0;
  logic [15:0] commit_delay = '0;
  logic        sample_tick = 1'b0;

  logic [79:0]  idx_bus  [2];
  logic [143:0] gain_bus [2];
  logic         rw [2];
  logic         rc [2];
  logic         bsy [2];
  logic         dn [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tone_cfg_sequencer #(.GAIN_STEP(1024)) u_dut_ramp (
    .clk(clk), .rst(rst),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(rw[0]), .cfg_wr_tone(cfg_wr_tone),
    .cfg_wr_index(cfg_wr_index), .cfg_wr_gain(cfg_wr_gain),
    .commit_valid(commit_valid), .commit_ready(rc[0]), .commit_delay(commit_delay),
    .sample_tick(sample_tick), .index_a_bus(idx_bus[0]), .gain_a_bus(gain_bus[0]),
    .busy(bsy[0]), .commit_done(dn[0])
  );

  tone_cfg_sequencer #(.GAIN_STEP(0)) u_dut_jump (
    .clk(clk), .rst(rst),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(rw[1]), .cfg_wr_tone(cfg_wr_tone),
    .cfg_wr_index(cfg_wr_index), .cfg_wr_gain(cfg_wr_gain),
    .commit_valid(commit_valid), .commit_ready(rc[1]), .commit_delay(commit_delay),
    .sample_tick(sample_tick), .index_a_bus(idx_bus[1]), .gain_a_bus(gain_bus[1]),
    .busy(bsy[1]), .commit_done(dn[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ifield(input int k, input int i);
    return int'(idx_bus[k][i*10 +: 10]);
  endfunction

  function automatic int gfield(input int k, input int i);
    return int'($signed(gain_bus[k][i*18 +: 18]));
  endfunction

  // Model: phase 0 = accepting, 1 = counting ticks to apply, 2 = ramping/done.
  int m_sh_idx [2][8];
  int m_sh_gain[2][8];
  int m_idx    [2][8];
  int m_gain   [2][8];
  int m_tgt    [2][8];
  int m_phase  [2];
  int m_left   [2];
  int m_rdy    [2];
  int m_bsy    [2];
  int m_dn     [2];

  function automatic int step_of(input int k);
    return (k == 0) ? 1024 : 0;
  endfunction

  function automatic bit settled(input int k);
    for (int i = 0; i < 8; i++) if (m_gain[k][i] != m_tgt[k][i]) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_left[k] = 0; m_rdy[k] = 0; m_bsy[k] = 0; m_dn[k] = 0;
      for (int i = 0; i < 8; i++) begin
        m_sh_idx[k][i] = 0; m_sh_gain[k][i] = 0; m_idx[k][i] = 0; m_gain[k][i] = 0; m_tgt[k][i] = 0;
      end
    end
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_phase[k] = 0; m_left[k] = 0; m_rdy[k] = 0; m_bsy[k] = 0; m_dn[k] = 0;
          for (int i = 0; i < 8; i++) begin
            m_sh_idx[k][i] = 0; m_sh_gain[k][i] = 0; m_idx[k][i] = 0; m_gain[k][i] = 0; m_tgt[k][i] = 0;
          end
        end else if (m_phase[k] == 0) begin
          if (m_rdy[k] != 0 && cfg_wr_valid) begin
            m_sh_idx[k][int'(cfg_wr_tone)]  = int'(cfg_wr_index);
            m_sh_gain[k][int'(cfg_wr_tone)] = int'($signed(cfg_wr_gain));
          end
          if (m_rdy[k] != 0 && commit_valid) begin
            m_phase[k] = 1; m_left[k] = int'(commit_delay) + 1; m_rdy[k] = 0; m_bsy[k] = 1;
          end else begin
            m_rdy[k] = 1;
          end
        end else if (m_phase[k] == 1) begin
          if (sample_tick) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              for (int i = 0; i < 8; i++) begin
                m_idx[k][i] = m_sh_idx[k][i];
                m_tgt[k][i] = m_sh_gain[k][i];
                if (step_of(k) == 0) m_gain[k][i] = m_tgt[k][i];
              end
              m_phase[k] = 2;
            end
          end
        end else begin
          if (m_dn[k] != 0) begin
            m_dn[k] = 0; m_phase[k] = 0; m_bsy[k] = 0; m_rdy[k] = 1;
          end else if (settled(k)) begin
            m_dn[k] = 1;
          end else if (sample_tick) begin
            for (int i = 0; i < 8; i++) begin
              int d;
              int s;
              d = m_tgt[k][i] - m_gain[k][i];
              s = step_of(k);
              if (s == 0) m_gain[k][i] = m_tgt[k][i];
              else if (d > 0) m_gain[k][i] += (d < s) ? d : s;
              else if (d < 0) m_gain[k][i] -= (-d < s) ? -d : s;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d cfg_wr_ready", k), int'(rw[k]), m_rdy[k]);
      chk($sformatf("dut%0d commit_ready", k), int'(rc[k]), m_rdy[k]);
      chk($sformatf("dut%0d busy", k), int'(bsy[k]), m_bsy[k]);
      chk($sformatf("dut%0d commit_done", k), int'(dn[k]), m_dn[k]);
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("dut%0d index[%0d]", k, i), ifield(k, i), m_idx[k][i]);
        chk($sformatf("dut%0d gain[%0d]", k, i), gfield(k, i), m_gain[k][i]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rw[0] && rw[1]) && n < 300) begin
      step();
      n++;
    end
    chk("idle_reached", int'(rw[0] && rw[1]), 1);
  endtask

  task automatic run_until_idle();
    sample_tick = 1'b1;
    wait_idle();
    sample_tick = 1'b0;
  endtask

  task automatic wr(input int tone, input int idx, input int gain);
    cfg_wr_valid = 1'b1;
    cfg_wr_tone  = 3'(tone);
    cfg_wr_index = 10'(idx);
    cfg_wr_gain  = 18'(gain);
    step();
    cfg_wr_valid = 1'b0;
  endtask

  task automatic commit(input int delay);
    commit_valid = 1'b1;
    commit_delay = 16'(delay);
    step();
    commit_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset cfg_wr_ready", int'(rw[k]), 0);
      chk("reset busy", int'(bsy[k]), 0);
      chk("reset commit_done", int'(dn[k]), 0);
      chk("reset index_bus_nonzero", int'(idx_bus[k] != '0), 0);
      chk("reset gain_bus_nonzero", int'(gain_bus[k] != '0), 0);
    end
    #1 rst = 1'b0;
    step();
    wait_idle();

    // Delay 0: jump instance applies index and gain together on the first tick.
    wr(3, 'h05A, 'h08000);
    commit(0);
    step(); step();
    chk("t1 index3 before tick", ifield(1, 3), 0);
    chk("t1 busy in wait", int'(bsy[1]), 1);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    chk("t1 index3 at apply", ifield(1, 3), 'h05A);
    chk("t1 gain3 at apply", gfield(1, 3), 'h08000);
    chk("t1 done not yet", int'(dn[1]), 0);
    #1 sample_tick = 1'b0;
    @(posedge clk); #1;
    chk("t1 done pulse", int'(dn[1]), 1);
    chk("t1 busy during done", int'(bsy[1]), 1);
    #1;
    run_until_idle();

    // Delay 3 with a tick every 4 cycles: applied on the 4th tick.
    wr(1, 'h123, 0);
    commit(3);
    for (int t = 1; t <= 4; t++) begin
      repeat (3) step();
      sample_tick = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("t2 index1 tick%0d", t), ifield(k, 1), (t == 4) ? 'h123 : 0);
        chk($sformatf("t2 busy tick%0d", t), int'(bsy[k]), 1);
      end
      #1 sample_tick = 1'b0;
    end
    wait_idle();

    // Positive ramp 0 -> 2560 on the stepping instance.
    wr(0, 'h001, 'h00A00);
    commit(0);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    chk("t3 gain0 at apply", gfield(0, 0), 0);
    chk("t3 jump gain0 at apply", gfield(1, 0), 2560);
    @(posedge clk); #1;
    chk("t3 gain0 tick1", gfield(0, 0), 1024);
    @(posedge clk); #1;
    chk("t3 gain0 tick2", gfield(0, 0), 2048);
    @(posedge clk); #1;
    chk("t3 gain0 tick3", gfield(0, 0), 2560);
    chk("t3 done not yet", int'(dn[0]), 0);
    #1 sample_tick = 1'b0;
    @(posedge clk); #1;
    chk("t3 done after tick3", int'(dn[0]), 1);
    chk("t3 no overshoot", gfield(0, 0), 2560);
    #1;
    wait_idle();

    // Negative ramp 1024 -> -1024.
    wr(0, 'h001, 'h00400);
    commit(0);
    run_until_idle();
    wr(0, 'h001, 'h3FC00);
    commit(0);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    chk("t4 gain0 at apply", gfield(0, 0), 1024);
    @(posedge clk); #1;
    chk("t4 gain0 tick1", gfield(0, 0), 0);
    @(posedge clk); #1;
    chk("t4 gain0 tick2", gfield(0, 0), -1024);
    #1 sample_tick = 1'b0;
    @(posedge clk); #1;
    chk("t4 done", int'(dn[0]), 1);
    #1;
    wait_idle();

    // Write and commit in the same cycle; a write during WAIT is refused.
    cfg_wr_valid = 1'b1; cfg_wr_tone = 3'd5; cfg_wr_index = 10'h2AA; cfg_wr_gain = '0;
    commit_valid = 1'b1; commit_delay = 16'd1;
    step();
    commit_valid = 1'b0;
    cfg_wr_index = 10'h3FF;
    chk("t5 wr_ready in wait", int'(rw[0]), 0);
    step();
    cfg_wr_valid = 1'b0;
    sample_tick = 1'b1;
    step();
    @(posedge clk); #1;
    chk("t5 index5 applied", ifield(0, 5), 'h2AA);
    chk("t5 jump index5 applied", ifield(1, 5), 'h2AA);
    #1 sample_tick = 1'b0;
    wait_idle();
    commit(0);
    sample_tick = 1'b1;
    @(posedge clk); #1;
    chk("t5 shadow unchanged", ifield(0, 5), 'h2AA);
    #1 sample_tick = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a ramp.
    wr(2, 'h007, 'h10000);
    commit(0);
    sample_tick = 1'b1;
    repeat (3) step();
    sample_tick = 1'b0;
    chk("t6 gain2 mid ramp", gfield(0, 2), 2048);
    #1 rst = 1'b1;
    #1;
    chk("t6 rst busy", int'(bsy[0]), 0);
    chk("t6 rst ready", int'(rw[0]), 0);
    chk("t6 rst index_bus_nonzero", int'(idx_bus[0] != '0), 0);
    chk("t6 rst gain_bus_nonzero", int'(gain_bus[0] != '0), 0);
    step(); step();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6 ready after rst", int'(rw[0]), 1);
    chk("t6 busy after rst", int'(bsy[0]), 0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
